// File: rtl/btn_evt.sv
// Button gesture classifier: turns a debounced button level into one-cycle
// short / double-click / long-press / auto-repeat event pulses.
module btn_evt #(
  parameter int unsigned TICK_DIV   = 16,
  parameter int unsigned TMR_WIDTH  = 8,
  parameter int unsigned LONG_TICKS = 100,
  parameter int unsigned DCLK_TICKS = 25,
  parameter int unsigned RPT_TICKS  = 10,
  parameter bit          DBL_EN     = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic btn_i,
  output logic evt_short_o,
  output logic evt_dbl_o,
  output logic evt_long_o,
  output logic evt_rpt_o,
  output logic busy_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]        PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [TMR_WIDTH-1:0] LONG_T    = TMR_WIDTH'(LONG_TICKS);
  localparam logic [TMR_WIDTH-1:0] DCLK_T    = TMR_WIDTH'(DCLK_TICKS);
  localparam logic [TMR_WIDTH-1:0] RPT_T     = TMR_WIDTH'(RPT_TICKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_WAIT2,
    S_PRESS2,
    S_LONG
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [TMR_WIDTH-1:0] timer_q, timer_d;
  logic                 short_q, short_d;
  logic                 dbl_q, dbl_d;
  logic                 long_q, long_d;
  logic                 rpt_q, rpt_d;
  logic                 restart;
  logic                 tmr_clr;
  logic                 tick;

  assign tick = (presc_q == PRESC_MAX);

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    short_d = 1'b0;
    dbl_d   = 1'b0;
    long_d  = 1'b0;
    rpt_d   = 1'b0;
    restart = 1'b0;

    if (!en_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (btn_i) state_d = S_PRESS1;
        end
        S_PRESS1: begin
          // Timeout wins over a release sampled on the same edge.
          if (timer_q == LONG_T) begin
            long_d  = 1'b1;
            state_d = btn_i ? S_LONG : S_IDLE;
          end else if (!btn_i) begin
            if (DBL_EN) begin
              state_d = S_WAIT2;
            end else begin
              short_d = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        S_WAIT2: begin
          if (btn_i) begin
            dbl_d   = 1'b1;
            state_d = S_PRESS2;
          end else if (timer_q == DCLK_T) begin
            short_d = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_PRESS2: begin
          if (!btn_i) state_d = S_IDLE;
        end
        S_LONG: begin
          if (!btn_i) begin
            state_d = S_IDLE;
          end else if ((RPT_TICKS != 0) && (timer_q == RPT_T)) begin
            rpt_d   = 1'b1;
            restart = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Timebase restarts on any state change and is held at zero while idle.
  assign tmr_clr = restart || (state_d != state_q) || (state_d == S_IDLE);

  always_comb begin
    presc_d = presc_q;
    timer_d = timer_q;
    if (tmr_clr) begin
      presc_d = '0;
      timer_d = '0;
    end else if (tick) begin
      presc_d = '0;
      if (timer_q != '1) timer_d = timer_q + TMR_WIDTH'(1);
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      timer_q <= '0;
      short_q <= 1'b0;
      dbl_q   <= 1'b0;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      timer_q <= timer_d;
      short_q <= short_d;
      dbl_q   <= dbl_d;
      long_q  <= long_d;
      rpt_q   <= rpt_d;
    end
  end

  assign evt_short_o = short_q;
  assign evt_dbl_o   = dbl_q;
  assign evt_long_o  = long_q;
  assign evt_rpt_o   = rpt_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_btn_evt.sv
// Scoreboard bench for btn_evt: two instances (double-click on / off) share
// stimulus; an elapsed-time reference model predicts every event pulse.
module tb_btn_evt;

  localparam int TD   = 4;
  localparam int LONG = 8;
  localparam int DCLK = 4;
  localparam int RPT  = 4;
  localparam int LONG_EDGES = LONG * TD;
  localparam int DCLK_EDGES = DCLK * TD;
  localparam int RPT_EDGES  = RPT * TD;

  typedef enum int {EV_NONE, EV_SHORT, EV_DBL, EV_LONG, EV_RPT} evt_e;
  typedef enum int {P_IDLE, P_PRESS1, P_WAIT2, P_PRESS2, P_LONG} phase_e;
  typedef struct {
    phase_e ph;
    int     k;
    evt_e   ev;
  } model_t;
  typedef struct {
    evt_e kind;
    int   cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic btn = 1'b0;
  logic s1, d1, l1, r1, busy1;
  logic s2, d2, l2, r2, busy2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int base    = 0;

  model_t m1 = '{P_IDLE, 0, EV_NONE};
  model_t m2 = '{P_IDLE, 0, EV_NONE};
  model_t n1, n2;
  exp_t   q1[$], q2[$];
  exp_t   alog1[$], alog2[$];

  always #5 clk = ~clk;

  btn_evt #(.TICK_DIV(TD), .TMR_WIDTH(8), .LONG_TICKS(LONG), .DCLK_TICKS(DCLK),
            .RPT_TICKS(RPT), .DBL_EN(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .btn_i(btn),
    .evt_short_o(s1), .evt_dbl_o(d1), .evt_long_o(l1), .evt_rpt_o(r1), .busy_o(busy1)
  );

  btn_evt #(.TICK_DIV(TD), .TMR_WIDTH(8), .LONG_TICKS(LONG), .DCLK_TICKS(DCLK),
            .RPT_TICKS(RPT), .DBL_EN(1'b0)) dut_nd (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .btn_i(btn),
    .evt_short_o(s2), .evt_dbl_o(d2), .evt_long_o(l2), .evt_rpt_o(r2), .busy_o(busy2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: k counts edges spent in the current phase; a timer value of N
  // is first seen on the edge where N*TD edges have elapsed since entry.
  function automatic model_t model_next(input bit dbl, input logic e, input logic b,
                                        input model_t m);
    model_t r;
    bit     restart;
    r       = m;
    r.ev    = EV_NONE;
    restart = 1'b0;
    if (!e) begin
      r.ph = P_IDLE;
    end else begin
      case (m.ph)
        P_IDLE:   if (b) r.ph = P_PRESS1;
        P_PRESS1: begin
          if (m.k == LONG_EDGES) begin
            r.ev = EV_LONG;
            r.ph = b ? P_LONG : P_IDLE;
          end else if (!b) begin
            r.ph = dbl ? P_WAIT2 : P_IDLE;
            if (!dbl) r.ev = EV_SHORT;
          end
        end
        P_WAIT2: begin
          if (b) begin
            r.ev = EV_DBL;
            r.ph = P_PRESS2;
          end else if (m.k == DCLK_EDGES) begin
            r.ev = EV_SHORT;
            r.ph = P_IDLE;
          end
        end
        P_PRESS2: if (!b) r.ph = P_IDLE;
        P_LONG: begin
          if (!b) begin
            r.ph = P_IDLE;
          end else if (RPT != 0 && m.k == RPT_EDGES) begin
            r.ev    = EV_RPT;
            restart = 1'b1;
          end
        end
        default: r.ph = P_IDLE;
      endcase
    end
    r.k = (r.ph != m.ph || restart) ? 0 : m.k + 1;
    return r;
  endfunction

  // Stimulus side of the scoreboard: predictions are queued per edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 <= '{P_IDLE, 0, EV_NONE};
      m2 <= '{P_IDLE, 0, EV_NONE};
      q1.delete();
      q2.delete();
    end else begin
      n1 = model_next(1'b1, en, btn, m1);
      n2 = model_next(1'b0, en, btn, m2);
      if (n1.ev != EV_NONE) q1.push_back('{n1.ev, cyc + 1});
      if (n2.ev != EV_NONE) q2.push_back('{n2.ev, cyc + 1});
      m1  <= n1;
      m2  <= n2;
      cyc <= cyc + 1;
    end
  end

  task automatic mon(input int id, input logic s, input logic d, input logic l,
                     input logic r, input logic busy, input bit exp_busy);
    evt_e act;
    exp_t e;
    bit   have;
    check($sformatf("busy%0d", id), int'(busy), int'(exp_busy));
    if (int'(s) + int'(d) + int'(l) + int'(r) > 1)
      check($sformatf("onehot%0d", id), int'(s) + int'(d) + int'(l) + int'(r), 1);
    act = s ? EV_SHORT : d ? EV_DBL : l ? EV_LONG : r ? EV_RPT : EV_NONE;
    if (act != EV_NONE) begin
      if (id == 1) alog1.push_back('{act, cyc});
      else         alog2.push_back('{act, cyc});
    end
    have = (id == 1) ? (q1.size() > 0) : (q2.size() > 0);
    if (have) e = (id == 1) ? q1[0] : q2[0];
    if (act != EV_NONE) begin
      if (!have) begin
        check($sformatf("unexpected_evt%0d", id), int'(act), int'(EV_NONE));
      end else begin
        if (id == 1) void'(q1.pop_front());
        else         void'(q2.pop_front());
        check($sformatf("evt_kind%0d", id), int'(act), int'(e.kind));
        check($sformatf("evt_cycle%0d", id), cyc, e.cyc);
      end
    end else if (have && e.cyc <= cyc) begin
      if (id == 1) void'(q1.pop_front());
      else         void'(q2.pop_front());
      check($sformatf("missing_evt%0d", id), int'(EV_NONE), int'(e.kind));
    end
  endtask

  // Checking side: runs on the falling edge, away from the sampling edge.
  always @(negedge clk) begin
    mon(1, s1, d1, l1, r1, busy1, m1.ph != P_IDLE);
    mon(2, s2, d2, l2, r2, busy2, m2.ph != P_IDLE);
  end

  task automatic hold(input logic b, input logic e, input int n);
    btn = b;
    en  = e;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_log(input string name, input int id, input int idx,
                         input evt_e kind, input int off);
    exp_t a;
    int   sz;
    sz = (id == 1) ? alog1.size() : alog2.size();
    if (idx < sz) begin
      a = (id == 1) ? alog1[idx] : alog2[idx];
      check({name, "_kind"}, int'(a.kind), int'(kind));
      check({name, "_edge"}, a.cyc - base, off);
    end else begin
      check({name, "_present"}, sz, idx + 1);
    end
  endtask

  task automatic start_test();
    alog1.delete();
    alog2.delete();
    base = cyc + 1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("rst_outs1", int'({s1, d1, l1, r1, busy1}), 0);
    check("rst_outs2", int'({s2, d2, l2, r2, busy2}), 0);
    rst_n = 1'b1;
    hold(0, 1, 5);

    // 1: single short press, reported after the double-click window
    start_test();
    hold(1, 1, 10);
    hold(0, 1, 40);
    check("t1_count", alog1.size(), 1);
    chk_log("t1_short", 1, 0, EV_SHORT, 27);
    chk_log("t1_nd_short", 2, 0, EV_SHORT, 10);

    // 2: double click
    start_test();
    hold(1, 1, 10);
    hold(0, 1, 8);
    hold(1, 1, 10);
    hold(0, 1, 40);
    check("t2_count", alog1.size(), 1);
    chk_log("t2_dbl", 1, 0, EV_DBL, 18);

    // 3: long press with auto-repeat, release without short
    start_test();
    hold(1, 1, 70);
    hold(0, 1, 40);
    check("t3_count", alog1.size(), 3);
    chk_log("t3_long", 1, 0, EV_LONG, 33);
    chk_log("t3_rpt0", 1, 1, EV_RPT, 50);
    chk_log("t3_rpt1", 1, 2, EV_RPT, 67);
    check("t3_busy", int'(busy1), 0);

    // 4: release on the exact long-press edge
    start_test();
    hold(1, 1, 33);
    hold(0, 1, 40);
    check("t4_count", alog1.size(), 1);
    chk_log("t4_long", 1, 0, EV_LONG, 33);
    check("t4_busy", int'(busy1), 0);

    // 5a: disable mid-press, then quiet period
    hold(1, 1, 5);
    hold(0, 0, 3);
    start_test();
    hold(0, 1, 100);
    check("t5a_count", alog1.size() + alog2.size(), 0);
    check("t5a_busy", int'(busy1), 0);

    // re-enable while held starts a new press
    hold(1, 0, 3);
    hold(1, 1, 2);
    check("t5_reen_busy", int'(busy1), 1);
    hold(0, 1, 40);

    // 5b: reset mid double-click window
    hold(1, 1, 10);
    hold(0, 1, 5);
    rst_n = 1'b0;
    hold(0, 1, 2);
    rst_n = 1'b1;
    start_test();
    hold(0, 1, 100);
    check("t5b_count", alog1.size() + alog2.size(), 0);
    check("t5b_busy", int'(busy1), 0);

    // 6: double-click detection off, two presses give two shorts
    start_test();
    hold(1, 1, 10);
    hold(0, 1, 4);
    hold(1, 1, 10);
    hold(0, 1, 40);
    check("t6_count", alog2.size(), 2);
    chk_log("t6_short0", 2, 0, EV_SHORT, 10);
    chk_log("t6_short1", 2, 1, EV_SHORT, 24);

    // Random gestures, disables and resets, checked by the scoreboard
    for (int i = 0; i < 200; i++) begin
      int r;
      r = int'($urandom_range(0, 39));
      if (r == 0) begin
        rst_n = 1'b0;
        hold(btn, en, int'($urandom_range(1, 3)));
        rst_n = 1'b1;
      end else if (r < 3) begin
        hold(logic'($urandom_range(0, 1)), 1'b0, int'($urandom_range(1, 6)));
      end else if ($urandom_range(0, 1) == 1) begin
        hold(~btn, 1'b1, int'($urandom_range(1, 20)));
      end else begin
        hold(~btn, 1'b1, int'($urandom_range(1, 80)));
      end
    end

    hold(0, 1, 60);
    check("drain_q1", q1.size(), 0);
    check("drain_q2", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
